// File: rtl/riscv_state_pkg.sv
// Shared types for the data-memory controller: funct3 access sizes, FSM states
// and the alignment rule used to reject accesses before they reach the bus.
package riscv_state_pkg;

    typedef enum logic [2:0] {
        SIZE_B   = 3'd0,
        SIZE_H   = 3'd1,
        SIZE_W   = 3'd2,
        SIZE_D   = 3'd3,
        SIZE_BU  = 3'd4,
        SIZE_HU  = 3'd5,
        SIZE_WU  = 3'd6,
        SIZE_RSV = 3'd7
    } size_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } dmem_state_e;

    // Doublewords are only legal on a 64-bit datapath; the reserved encoding is always rejected.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [2:0] adr_lo,
                                           input logic xlen64);
        case (size)
            SIZE_B, SIZE_BU: return 1'b0;
            SIZE_H, SIZE_HU: return adr_lo[0];
            SIZE_W, SIZE_WU: return |adr_lo[1:0];
            SIZE_D:          return ~xlen64 | (|adr_lo);
            default:         return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/riscv_dmem_be_gen.sv
// Byte-lane steering for data-memory stores: byte enables starting at the
// address lane offset and store data shifted up into those lanes.
module riscv_dmem_be_gen #(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]                    size,
    input  logic [$clog2(XLEN/8)-1:0]     off,
    input  logic [XLEN-1:0]               d,
    output logic [7:0]                    be,
    output logic [XLEN-1:0]               data
);
    localparam int unsigned LANES     = XLEN / 8;
    localparam logic [7:0]  LANE_MASK = 8'((16'd1 << LANES) - 16'd1);

    logic [7:0] span;

    always_comb begin
        case (size)
            2'd0:    span = 8'h01;
            2'd1:    span = 8'h03;
            2'd2:    span = 8'h0F;
            default: span = 8'hFF;
        endcase
        be   = 8'(span << off) & LANE_MASK;
        data = d << {off, 3'b000};
    end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Load/store unit bus front end: issues aligned accesses, tracks up to DEPTH
// in-order outstanding responses and discards responses owed to flushed work.
module riscv_dmem_ctrl
    import riscv_state_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [2:0]      size_i,
    input  logic [XLEN-1:0] adr_i,
    input  logic [XLEN-1:0] d_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            ack_o,
    output logic            err_o,
    output logic            misaligned_o,
    output logic [XLEN-1:0] q_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_adr_o,
    output logic [XLEN-1:0] bus_d_o,
    output logic [7:0]      bus_be_o,
    input  logic            bus_gnt_i,
    input  logic            bus_rvalid_i,
    input  logic            bus_err_i,
    input  logic [XLEN-1:0] bus_q_i
);
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned OFFW = $clog2(XLEN / 8);

    dmem_state_e     state;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic            mis_pend;

    logic            pend_valid;
    logic            pend_we;
    logic [XLEN-1:0] pend_adr;
    logic [XLEN-1:0] pend_d;
    logic [7:0]      pend_be;

    logic [7:0]      new_be;
    logic [XLEN-1:0] new_d;
    logic            running;
    logic            resp;
    logic            full;
    logic            misal;
    logic            accept;
    logic            issue_new;
    logic            inc;
    logic [CW-1:0]   cnt_next;
    logic [CW-1:0]   discard_next;

    riscv_dmem_be_gen #(.XLEN(XLEN)) u_be_gen (
        .size (size_i[1:0]),
        .off  (adr_i[OFFW-1:0]),
        .d    (d_i),
        .be   (new_be),
        .data (new_d)
    );

    assign running   = (state == ST_RUN);
    assign resp      = bus_rvalid_i & (outstanding != '0);
    assign full      = (outstanding == CW'(DEPTH)) & ~resp;
    // A held request blocks new ones, so each accepted access reaches the bus in its own cycle.
    assign stall_o   = ~running | pend_valid | full;
    assign misal     = is_misaligned(size_i, adr_i[2:0], XLEN == 64);
    assign accept    = req_i & ~stall_o & ~flush_i;
    assign issue_new = accept & ~misal;

    assign bus_req_o = (pend_valid & ~flush_i) | issue_new;
    assign bus_we_o  = pend_valid ? pend_we  : we_i;
    assign bus_adr_o = pend_valid ? pend_adr : adr_i;
    assign bus_d_o   = pend_valid ? pend_d   : new_d;
    assign bus_be_o  = pend_valid ? pend_be  : new_be;

    assign inc          = bus_req_o & bus_gnt_i;
    assign cnt_next     = outstanding + CW'(inc) - CW'(resp);
    assign discard_next = flush_i ? cnt_next : discard - CW'(resp);

    assign q_o          = bus_q_i;
    assign ack_o        = resp & ~bus_err_i & running & ~flush_i;
    assign err_o        = resp &  bus_err_i & running & ~flush_i;
    // The misaligned pulse yields to a same-cycle bus response to keep completions exclusive.
    assign misaligned_o = mis_pend & running & ~flush_i & ~resp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_RUN;
            outstanding <= '0;
            discard     <= '0;
            mis_pend    <= 1'b0;
            pend_valid  <= 1'b0;
            pend_we     <= 1'b0;
            pend_adr    <= '0;
            pend_d      <= '0;
            pend_be     <= '0;
        end else begin
            outstanding <= cnt_next;

            if (flush_i || bus_gnt_i) pend_valid <= 1'b0;
            if (issue_new && !bus_gnt_i) begin
                pend_valid <= 1'b1;
                pend_we    <= we_i;
                pend_adr   <= adr_i;
                pend_d     <= new_d;
                pend_be    <= new_be;
            end

            if (accept && misal)               mis_pend <= 1'b1;
            else if (flush_i || misaligned_o)  mis_pend <= 1'b0;

            unique case (state)
                ST_RUN: begin
                    if (flush_i && cnt_next != '0) begin
                        state   <= ST_DRAIN;
                        discard <= cnt_next;
                    end
                end
                ST_DRAIN: begin
                    discard <= discard_next;
                    if (discard_next == '0) state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Self-checking bench for riscv_dmem_ctrl (XLEN=32, DEPTH=2): lane vectors,
// directed flush/reset sequences and randomized traffic against a reference model.
module tb_riscv_dmem_ctrl;
    import riscv_state_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            req_i, we_i, flush_i;
    logic [2:0]      size_i;
    logic [XLEN-1:0] adr_i, d_i;
    logic            stall_o, ack_o, err_o, misaligned_o;
    logic [XLEN-1:0] q_o;
    logic            bus_req_o, bus_we_o;
    logic [XLEN-1:0] bus_adr_o, bus_d_o;
    logic [7:0]      bus_be_o;
    logic            bus_gnt_i, bus_rvalid_i, bus_err_i;
    logic [XLEN-1:0] bus_q_i;

    always #5 clk_i = ~clk_i;

    riscv_dmem_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .adr_i(adr_i), .d_i(d_i), .flush_i(flush_i), .stall_o(stall_o), .ack_o(ack_o),
        .err_o(err_o), .misaligned_o(misaligned_o), .q_o(q_o), .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o), .bus_d_o(bus_d_o), .bus_be_o(bus_be_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_err_i(bus_err_i),
        .bus_q_i(bus_q_i)
    );

    typedef struct {
        bit          req, we;
        logic [2:0]  size;
        logic [31:0] adr, d;
        bit          flush, gnt, rvalid, berr;
        logic [31:0] bq;
    } in_t;

    typedef struct {
        bit          we;
        logic [2:0]  size;
        logic [31:0] adr, d;
        logic [7:0]  be;
        logic [31:0] dout;
        bit          mis;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Reference model state: accesses in flight, draining flag, held bus request, owed misaligned pulse.
    int          m_out;
    bit          m_drain, m_pend, m_mis;
    bit          p_we;
    logic [31:0] p_adr, p_d;
    logic [7:0]  p_be;

    logic        s_stall, s_bus_req, s_ack, s_err, s_mis;
    logic [7:0]  s_be;
    logic [31:0] s_d, s_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic in_t idle_in();
        in_t r;
        r = '{default: '0};
        return r;
    endfunction

    function automatic int nbytes(input logic [2:0] s);
        case (s[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] s, input logic [31:0] adr);
        if (s == 3'd7 || s == 3'd3) return 1'b1;
        return (adr % nbytes(s)) != 0;
    endfunction

    function automatic logic [7:0] ref_be(input logic [2:0] s, input logic [31:0] adr);
        logic [7:0] be;
        int off;
        be  = '0;
        off = int'(adr % 4);
        for (int i = 0; i < nbytes(s); i++)
            if (off + i < 4) be[off + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_data(input logic [31:0] d, input logic [31:0] adr);
        longint unsigned prod;
        prod = longint'(d) * (64'd1 << (8 * (adr % 4)));
        return prod[31:0];
    endfunction

    task automatic drive(input in_t x);
        req_i = x.req; we_i = x.we; size_i = x.size; adr_i = x.adr; d_i = x.d;
        flush_i = x.flush; bus_gnt_i = x.gnt; bus_rvalid_i = x.rvalid;
        bus_err_i = x.berr; bus_q_i = x.bq;
    endtask

    task automatic cycle(input in_t x);
        bit resp, e_stall, acc, mis, e_req, e_ack, e_err, e_mis, granted;
        int new_out;
        drive(x);
        #2;
        s_stall = stall_o; s_bus_req = bus_req_o; s_ack = ack_o; s_err = err_o;
        s_mis = misaligned_o; s_be = bus_be_o; s_d = bus_d_o; s_q = q_o;

        resp    = x.rvalid && m_out > 0;
        e_stall = m_drain || m_pend || (m_out == DEPTH && !resp);
        acc     = x.req && !e_stall && !x.flush;
        mis     = ref_misaligned(x.size, x.adr);
        e_req   = (m_pend && !x.flush) || (acc && !mis);
        e_ack   = resp && !x.berr && !m_drain && !x.flush;
        e_err   = resp &&  x.berr && !m_drain && !x.flush;
        e_mis   = m_mis && !m_drain && !x.flush && !resp;

        check("stall", s_stall, e_stall);
        check("bus_req", s_bus_req, e_req);
        check("ack", s_ack, e_ack);
        check("err", s_err, e_err);
        check("misaligned", s_mis, e_mis);
        if (e_ack) check("q", s_q, x.bq);
        if (e_req) begin
            check("bus_we",  bus_we_o,  m_pend ? p_we  : x.we);
            check("bus_adr", bus_adr_o, m_pend ? p_adr : x.adr);
            check("bus_d",   s_d,       m_pend ? p_d   : ref_data(x.d, x.adr));
            check("bus_be",  s_be,      m_pend ? p_be  : ref_be(x.size, x.adr));
        end

        @(posedge clk_i);
        #1;

        granted = e_req && x.gnt;
        new_out = m_out + int'(granted) - int'(resp);
        if (m_pend && (x.flush || x.gnt)) m_pend = 1'b0;
        if (acc && !mis && !x.gnt) begin
            m_pend = 1'b1; p_we = x.we; p_adr = x.adr;
            p_d = ref_data(x.d, x.adr); p_be = ref_be(x.size, x.adr);
        end
        if (acc && mis)              m_mis = 1'b1;
        else if (x.flush || e_mis)   m_mis = 1'b0;
        if (x.flush)                      m_drain = (new_out != 0);
        else if (m_drain && new_out == 0) m_drain = 1'b0;
        m_out = new_out;
    endtask

    task automatic do_reset();
        in_t x;
        x = idle_in();
        x.rvalid = 1'b1;
        x.bq = 32'h5555_AAAA;
        drive(x);
        rst_ni = 1'b0;
        #2;
        check("rst_stall", stall_o, 1'b0);
        check("rst_bus_req", bus_req_o, 1'b0);
        check("rst_ack", ack_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_misaligned", misaligned_o, 1'b0);
        m_out = 0; m_drain = 1'b0; m_pend = 1'b0; m_mis = 1'b0;
        @(posedge clk_i);
        #1;
        drive(idle_in());
        rst_ni = 1'b1;
    endtask

    function automatic in_t lw(input logic [31:0] adr, input bit gnt);
        in_t r;
        r = idle_in();
        r.req = 1'b1; r.size = 3'd2; r.adr = adr; r.gnt = gnt;
        return r;
    endfunction

    function automatic in_t rsp(input bit berr, input logic [31:0] q);
        in_t r;
        r = idle_in();
        r.rvalid = 1'b1; r.berr = berr; r.bq = q;
        return r;
    endfunction

    vec_t vecs[10];

    initial begin
        in_t x;

        vecs[0] = '{1'b0, 3'd2, 32'h100, 32'h0,        8'h0F, 32'h0,        1'b0};
        vecs[1] = '{1'b1, 3'd1, 32'h102, 32'h1234,     8'h0C, 32'h12340000, 1'b0};
        vecs[2] = '{1'b1, 3'd0, 32'h103, 32'hAB,       8'h08, 32'hAB000000, 1'b0};
        vecs[3] = '{1'b0, 3'd4, 32'h201, 32'h0,        8'h02, 32'h0,        1'b0};
        vecs[4] = '{1'b1, 3'd1, 32'h100, 32'h5678,     8'h03, 32'h5678,     1'b0};
        vecs[5] = '{1'b0, 3'd1, 32'h101, 32'h0,        8'h00, 32'h0,        1'b1};
        vecs[6] = '{1'b0, 3'd2, 32'h102, 32'h0,        8'h00, 32'h0,        1'b1};
        vecs[7] = '{1'b0, 3'd3, 32'h100, 32'h0,        8'h00, 32'h0,        1'b1};
        vecs[8] = '{1'b1, 3'd2, 32'h104, 32'hCAFEF00D, 8'h0F, 32'hCAFEF00D, 1'b0};
        vecs[9] = '{1'b0, 3'd5, 32'h106, 32'h0,        8'h0C, 32'h0,        1'b0};

        drive(idle_in());
        @(posedge clk_i);
        #1;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            x = idle_in();
            x.req = 1'b1; x.we = vecs[i].we; x.size = vecs[i].size;
            x.adr = vecs[i].adr; x.d = vecs[i].d; x.gnt = 1'b1;
            cycle(x);
            check($sformatf("vec%0d_bus_req", i), s_bus_req, !vecs[i].mis);
            if (!vecs[i].mis) begin
                check($sformatf("vec%0d_be", i), s_be, vecs[i].be);
                check($sformatf("vec%0d_d", i), s_d, vecs[i].dout);
            end
            x = vecs[i].mis ? idle_in() : rsp(1'b0, 32'h1000 + i);
            cycle(x);
            check($sformatf("vec%0d_misaligned", i), s_mis, vecs[i].mis);
            check($sformatf("vec%0d_ack", i), s_ack, !vecs[i].mis);
        end

        // LW with delayed response
        cycle(lw(32'h100, 1'b1));
        check("lw_be", s_be, 8'h0F);
        cycle(idle_in());
        cycle(rsp(1'b0, 32'hDEADBEEF));
        check("lw_ack", s_ack, 1'b1);
        check("lw_q", s_q, 32'hDEADBEEF);

        // Misaligned LH keeps the counter at zero: a later stray rvalid is ignored
        x = idle_in(); x.req = 1'b1; x.size = 3'd1; x.adr = 32'h101; x.gnt = 1'b1;
        cycle(x);
        check("lh_mis_no_req", s_bus_req, 1'b0);
        cycle(rsp(1'b0, 32'h1));
        check("lh_mis_pulse", s_mis, 1'b1);
        check("lh_mis_no_ack", s_ack, 1'b0);

        // Three back-to-back LWs against DEPTH=2
        cycle(lw(32'h200, 1'b1));
        check("b2b_1_stall", s_stall, 1'b0);
        cycle(lw(32'h204, 1'b1));
        check("b2b_2_stall", s_stall, 1'b0);
        cycle(lw(32'h208, 1'b1));
        check("b2b_3_stall", s_stall, 1'b1);
        cycle(lw(32'h208, 1'b1));
        check("b2b_3_stall_again", s_stall, 1'b1);
        x = lw(32'h208, 1'b1); x.rvalid = 1'b1; x.bq = 32'h11;
        cycle(x);
        check("b2b_3_accept", s_stall, 1'b0);
        check("b2b_3_req", s_bus_req, 1'b1);
        cycle(rsp(1'b0, 32'h22));
        cycle(rsp(1'b0, 32'h33));
        check("b2b_drained_ack", s_ack, 1'b1);

        // Flush with two in flight, drain, then recover
        cycle(lw(32'h300, 1'b1));
        cycle(lw(32'h304, 1'b1));
        x = idle_in(); x.flush = 1'b1;
        cycle(x);
        cycle(lw(32'h308, 1'b1));
        check("drain_stall", s_stall, 1'b1);
        cycle(rsp(1'b0, 32'hA1));
        check("drain_ack1", s_ack, 1'b0);
        cycle(rsp(1'b0, 32'hA2));
        check("drain_ack2", s_ack, 1'b0);
        cycle(lw(32'h30C, 1'b1));
        check("post_drain_accept", s_stall, 1'b0);
        cycle(rsp(1'b0, 32'hB0));
        check("post_drain_ack", s_ack, 1'b1);

        // Bus error frees a slot
        cycle(lw(32'h400, 1'b1));
        cycle(lw(32'h404, 1'b1));
        cycle(rsp(1'b1, 32'h0));
        check("berr_err", s_err, 1'b1);
        check("berr_ack", s_ack, 1'b0);
        cycle(lw(32'h408, 1'b1));
        check("berr_slot_free", s_stall, 1'b0);
        cycle(rsp(1'b0, 32'h1));
        cycle(rsp(1'b0, 32'h2));

        // Ungranted request withdrawn by flush; misaligned pulse killed by flush
        cycle(lw(32'h500, 1'b0));
        x = idle_in(); x.flush = 1'b1;
        cycle(x);
        check("flush_withdraw", s_bus_req, 1'b0);
        x = idle_in(); x.req = 1'b1; x.size = 3'd2; x.adr = 32'h502;
        cycle(x);
        x = idle_in(); x.flush = 1'b1;
        cycle(x);
        check("flush_kills_mis", s_mis, 1'b0);

        // Reset mid-access abandons in-flight responses
        cycle(lw(32'h600, 1'b1));
        cycle(lw(32'h604, 1'b1));
        do_reset();
        cycle(rsp(1'b0, 32'h77));
        check("post_reset_no_ack", s_ack, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            x = idle_in();
            x.req    = ($urandom_range(0, 9) < 6);
            x.we     = $urandom_range(0, 1);
            x.size   = 3'($urandom_range(0, 7));
            x.adr    = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3));
            x.d      = $urandom;
            x.flush  = ($urandom_range(0, 19) == 0);
            x.gnt    = ($urandom_range(0, 9) < 7);
            x.rvalid = (m_out > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
            x.berr   = ($urandom_range(0, 4) == 0);
            x.bq     = $urandom;
            cycle(x);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
